jk_register_bank: RTL and testbench



---
 rtl/jk_register_bank.sv | 102 ++++++++++
 tb/tb_jk_register_bank.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/jk_register_bank.sv
// jk_register_bank: WIDTH-bit bank of J-K state bits with mode-selected
// counting and shifting, synchronous preset/clear/load, and a registered
// wrap pulse for cascading. Active clock edge is chosen by InvertClockEnable.
module jk_register_bank #(
    parameter int               WIDTH             = 8,
    parameter bit               InvertClockEnable = 1'b1,
    parameter logic [WIDTH-1:0] RESET_VALUE       = '0,
    parameter logic [WIDTH-1:0] PRESET_VALUE      = '1
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             preset,
    input  logic             clear,
    input  logic             load,
    input  logic [WIDTH-1:0] load_data,
    input  logic             tick,
    input  logic [1:0]       mode,
    input  logic [WIDTH-1:0] j,
    input  logic [WIDTH-1:0] k,
    input  logic             serial_in,
    output logic [WIDTH-1:0] q,
    output logic [WIDTH-1:0] qBar,
    output logic             serial_out,
    output logic             terminal_count,
    output logic             wrap_pulse
);

    localparam logic [1:0] MODE_JK  = 2'b00;
    localparam logic [1:0] MODE_UP  = 2'b01;
    localparam logic [1:0] MODE_DN  = 2'b10;
    localparam logic [1:0] MODE_SHL = 2'b11;

    logic [WIDTH-1:0] state_q, state_d;
    logic             wrap_q, wrap_d;
    logic [WIDTH-1:0] shl_w;
    logic             active_clk;

    // Classic J-K characteristic equation applied bitwise.
    function automatic logic [WIDTH-1:0] jk_next(input logic [WIDTH-1:0] cur,
                                                 input logic [WIDTH-1:0] jj,
                                                 input logic [WIDTH-1:0] kk);
        return (~cur & jj) | (cur & ~kk);
    endfunction

    // Falling-edge operation is obtained by inverting the clock feeding the bank.
    assign active_clk = InvertClockEnable ? ~clock : clock;

    // A one-bit bank has nothing to shift; the serial input simply replaces it.
    generate
        if (WIDTH == 1) begin : g_shl_w1
            assign shl_w = serial_in;
        end else begin : g_shl_wn
            assign shl_w = {state_q[WIDTH-2:0], serial_in};
        end
    endgenerate

    // Next-state selection: preset > clear > load > tick-enabled mode op > hold.
    always_comb begin
        state_d = state_q;
        wrap_d  = 1'b0;
        if (preset) begin
            state_d = PRESET_VALUE;
        end else if (clear) begin
            state_d = '0;
        end else if (load) begin
            state_d = load_data;
        end else if (tick) begin
            case (mode)
                MODE_JK:  state_d = jk_next(state_q, j, k);
                MODE_UP: begin
                    state_d = state_q + 1'b1;
                    wrap_d  = &state_q;
                end
                MODE_DN: begin
                    state_d = state_q - 1'b1;
                    wrap_d  = ~|state_q;
                end
                default:  state_d = shl_w;
            endcase
        end
    end

    // State and wrap pulse registers; reset acts immediately.
    always_ff @(posedge active_clk or posedge reset) begin
        if (reset) begin
            state_q <= RESET_VALUE;
            wrap_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            wrap_q  <= wrap_d;
        end
    end

    assign q              = state_q;
    assign qBar           = ~state_q;
    assign serial_out     = state_q[WIDTH-1];
    assign wrap_pulse     = wrap_q;
    // Terminal count looks at the selected mode only, independent of tick.
    assign terminal_count = ((mode == MODE_UP) && (&state_q)) ||
                            ((mode == MODE_DN) && (~|state_q));

endmodule

// File: tb/tb_jk_register_bank.sv
// Scoreboard bench for jk_register_bank at WIDTH=4, falling-edge active.
// Stimulus pushes hand-computed expectations; a monitor pops and compares
// on the rising (inactive) edge or on an explicit sample event.
module tb_jk_register_bank;

    localparam int W = 4;

    logic         clock = 1'b0;
    logic         reset = 1'b0;
    logic         preset = 1'b0, clear = 1'b0, load = 1'b0, tick = 1'b0;
    logic         serial_in = 1'b0;
    logic [W-1:0] load_data = '0, j = '0, k = '0;
    logic [1:0]   mode = 2'b00;
    logic [W-1:0] q, qBar;
    logic         serial_out, terminal_count, wrap_pulse;

    typedef struct {
        string        name;
        logic [W-1:0] q;
        logic         wrap;
        logic         tc;
    } exp_t;

    exp_t sb[$];
    int   tests = 0;
    int   fails = 0;
    event sample_ev;

    jk_register_bank #(.WIDTH(W)) dut (
        .clock(clock), .reset(reset), .preset(preset), .clear(clear),
        .load(load), .load_data(load_data), .tick(tick), .mode(mode),
        .j(j), .k(k), .serial_in(serial_in), .q(q), .qBar(qBar),
        .serial_out(serial_out), .terminal_count(terminal_count),
        .wrap_pulse(wrap_pulse)
    );

    always #5 clock = ~clock;

    task automatic check(input string nm, input string fld,
                         input logic [W-1:0] act, input logic [W-1:0] expv);
        tests++;
        if (act !== expv) begin
            fails++;
            $display("FAIL %s.%s: got 0x%0h, expected 0x%0h", nm, fld, act, expv);
        end
    endtask

    // Monitor: drain every queued expectation at each sample point.
    initial begin
        exp_t e;
        forever begin
            @(posedge clock or sample_ev);
            while (sb.size() > 0) begin
                e = sb.pop_front();
                check(e.name, "q",    q,                        e.q);
                check(e.name, "qBar", qBar,                     ~e.q);
                check(e.name, "wrap", {3'b000, wrap_pulse},     {3'b000, e.wrap});
                check(e.name, "tc",   {3'b000, terminal_count}, {3'b000, e.tc});
                check(e.name, "sout", {3'b000, serial_out},     {3'b000, e.q[W-1]});
            end
        end
    end

    task automatic drive(input logic pr, input logic cl, input logic ld,
                         input logic [W-1:0] ldd, input logic tk,
                         input logic [1:0] md, input logic [W-1:0] jj,
                         input logic [W-1:0] kk, input logic si);
        preset = pr; clear = cl; load = ld; load_data = ldd; tick = tk;
        mode = md; j = jj; k = kk; serial_in = si;
    endtask

    // One active (falling) edge, then queue the expected post-edge view.
    task automatic step(input string nm, input logic [W-1:0] eq,
                        input logic ew, input logic etc);
        exp_t e;
        @(negedge clock);
        #1;
        e.name = nm; e.q = eq; e.wrap = ew; e.tc = etc;
        sb.push_back(e);
        @(posedge clock);
        #1;
    endtask

    // Assert reset between edges and check the immediate effect.
    task automatic async_reset(input string nm, input logic etc);
        exp_t e;
        #1 reset = 1'b1;
        #1;
        e.name = nm; e.q = '0; e.wrap = 1'b0; e.tc = etc;
        sb.push_back(e);
        -> sample_ev;
        #1 reset = 1'b0;
    endtask

    initial begin
        #1 reset = 1'b1;
        drive(0, 0, 0, 4'h0, 0, 2'b00, 4'h0, 4'h0, 0);
        step("reset_hold", 4'h0, 0, 0);
        reset = 1'b0;

        // Async reset mid-cycle with q=9
        drive(0, 0, 1, 4'h9, 0, 2'b00, 4'h0, 4'h0, 0);
        step("load9", 4'h9, 0, 0);
        drive(0, 0, 0, 4'h0, 0, 2'b00, 4'h0, 4'h0, 0);
        async_reset("rst_async", 0);
        step("rst_release", 4'h0, 0, 0);

        // Count up through wrap
        drive(0, 0, 1, 4'hE, 0, 2'b00, 4'h0, 4'h0, 0);
        step("loadE", 4'hE, 0, 0);
        drive(0, 0, 0, 4'h0, 1, 2'b01, 4'h0, 4'h0, 0);
        step("up_F", 4'hF, 0, 1);
        step("up_wrap", 4'h0, 1, 0);
        step("up_1", 4'h1, 0, 0);

        // Count down with tick every other cycle
        drive(0, 0, 0, 4'h0, 1, 2'b10, 4'h0, 4'h0, 0);
        step("dn_0", 4'h0, 0, 1);
        tick = 1'b0;
        step("dn_hold0", 4'h0, 0, 1);
        tick = 1'b1;
        step("dn_wrap", 4'hF, 1, 0);
        tick = 1'b0;
        step("dn_holdF", 4'hF, 0, 0);
        tick = 1'b1;
        step("dn_E", 4'hE, 0, 0);

        // Per-bit J-K
        drive(0, 0, 1, 4'hA, 0, 2'b00, 4'h0, 4'h0, 0);
        step("loadA", 4'hA, 0, 0);
        drive(0, 0, 0, 4'h0, 1, 2'b00, 4'h5, 4'hC, 0);
        step("jk_mix", 4'h7, 0, 0);
        drive(0, 0, 0, 4'h0, 1, 2'b00, 4'hF, 4'hF, 0);
        step("jk_toggle", 4'h8, 0, 0);
        drive(0, 0, 0, 4'h0, 1, 2'b00, 4'h0, 4'h0, 0);
        step("jk_hold", 4'h8, 0, 0);
        drive(0, 0, 0, 4'h0, 0, 2'b00, 4'hF, 4'h0, 0);
        step("jk_notick", 4'h8, 0, 0);

        // Shift left
        drive(0, 1, 0, 4'h0, 0, 2'b11, 4'h0, 4'h0, 0);
        step("shl_clear", 4'h0, 0, 0);
        drive(0, 0, 0, 4'h0, 1, 2'b11, 4'hF, 4'hF, 1);
        step("shl_1", 4'h1, 0, 0);
        serial_in = 1'b0;
        step("shl_2", 4'h2, 0, 0);
        serial_in = 1'b1;
        step("shl_5", 4'h5, 0, 0);
        step("shl_B", 4'hB, 0, 0);
        serial_in = 1'b0;
        step("shl_6", 4'h6, 0, 0);

        // Priority of preset/clear/load
        drive(1, 1, 1, 4'h3, 0, 2'b00, 4'h0, 4'h0, 0);
        step("prio_preset", 4'hF, 0, 0);
        drive(0, 1, 0, 4'h3, 0, 2'b00, 4'h0, 4'h0, 0);
        step("prio_clear", 4'h0, 0, 0);
        drive(0, 0, 1, 4'h3, 0, 2'b00, 4'h0, 4'h0, 0);
        step("prio_load", 4'h3, 0, 0);
        drive(0, 0, 1, 4'hF, 1, 2'b01, 4'h0, 4'h0, 0);
        step("load_over_tick", 4'hF, 0, 1);
        drive(1, 0, 0, 4'h0, 1, 2'b01, 4'h0, 4'h0, 0);
        step("preset_no_wrap", 4'hF, 0, 1);
        drive(0, 0, 0, 4'h0, 1, 2'b01, 4'h0, 4'h0, 0);
        step("wrap_again", 4'h0, 1, 0);
        drive(0, 0, 0, 4'h0, 0, 2'b10, 4'h0, 4'h0, 0);
        step("wrap_clears", 4'h0, 0, 1);

        // Reset mid-count resumes from the reset value
        drive(0, 0, 0, 4'h0, 1, 2'b01, 4'h0, 4'h0, 0);
        step("cnt_1", 4'h1, 0, 0);
        step("cnt_2", 4'h2, 0, 0);
        async_reset("rst_midcount", 0);
        step("cnt_resume", 4'h1, 0, 0);

        tick = 1'b0;
        repeat (2) @(posedge clock);
        #1;
        tests++;
        if (sb.size() != 0) begin
            fails++;
            $display("FAIL drain: %0d entries left, expected 0", sb.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
